tx_ser_ctrl: RTL

Transmit-side word scheduler that feeds the 10-bit parallel-to-serial shifter in the TX path. Runs on the bit clock and divides it into 10-cycle frames. At each frame boundary it picks the next 10-bit word: an alignment comma pattern, upstream encoded data, an idle word or a skip word. It drives that word plus a one-cycle load strobe to the serializer and throttles upstream with a ready handshake.

---
 rtl/tx_ctrl_pkg.sv | 18 +
 rtl/tx_frame_counter.sv | 29 ++
 rtl/tx_ser_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tx_ctrl_pkg.sv
// Shared types and code words for the TX word scheduler.
// Holds the scheduler state type, the K28.5 comma codes and the word width.
package tx_ctrl_pkg;

    localparam int WORD_W    = 10;
    localparam int BIT_CNT_W = 4;

    localparam logic [WORD_W-1:0] K28_5_RDN         = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28_5_RDP         = 10'b1100000101;
    localparam logic [WORD_W-1:0] IDLE_CODE_DEFAULT = K28_5_RDN;
    localparam logic [WORD_W-1:0] SKIP_CODE_DEFAULT = 10'b0011110100;

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_DATA  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/tx_frame_counter.sv
// Divides the bit clock into frames of WORD_W cycles.
// The counter rests on the last position during reset so that the very first
// edge after release is a frame boundary.
module tx_frame_counter
    import tx_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic boundary
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    logic [BIT_CNT_W-1:0] bit_cnt;

    assign boundary = (bit_cnt == LAST_BIT);

    // Position within the current frame, wrapping at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= LAST_BIT;
        end else if (boundary) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_ser_ctrl.sv
// Transmit word scheduler feeding the 10-bit serializer.
// At every frame boundary it picks a comma (alignment), upstream data, an idle
// word or a skip word, loads it onto ser_word and strobes ser_load.
// Optional feature: define TX_SKIP_EN to insert SKIP_WORD after every
// SKIP_INTERVAL data-phase words.
module tx_ser_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int                ALIGN_WORDS   = 16,
    parameter logic [WORD_W-1:0] COMMA_A       = K28_5_RDN,
    parameter logic [WORD_W-1:0] COMMA_B       = K28_5_RDP,
    parameter logic [WORD_W-1:0] IDLE_WORD     = IDLE_CODE_DEFAULT,
    parameter logic [WORD_W-1:0] SKIP_WORD     = SKIP_CODE_DEFAULT,
    parameter int                SKIP_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              train_req,
    output logic [WORD_W-1:0] ser_word,
    output logic              ser_load,
    output logic              link_up,
    output logic              idle_sent
);

    localparam int                 ACNT_W      = $clog2(ALIGN_WORDS + 1);
    localparam logic [ACNT_W-1:0]  ALIGN_LIMIT = ACNT_W'(ALIGN_WORDS);

    // Reject configurations the comma alternation and skip spacing cannot honour.
    if (ALIGN_WORDS < 2 || (ALIGN_WORDS % 2) != 0 || SKIP_INTERVAL < 2) begin : g_bad_params
        $error("tx_ser_ctrl: ALIGN_WORDS must be even and >=2, SKIP_INTERVAL must be >=2");
    end

    logic              boundary;
    tx_state_t         state;
    logic [ACNT_W-1:0] align_cnt;
    logic              train_pend;
    logic              train_now;
    logic              align_done;
    logic              data_phase;
    logic              skip_due;
    logic [WORD_W-1:0] next_word;
    logic              next_idle;

    tx_frame_counter u_frame_counter (
        .clk      (clk),
        .rst      (rst),
        .boundary (boundary)
    );

    // A train request seen in the boundary cycle itself is honoured at once.
    assign train_now  = train_pend | train_req;
    // The boundary that completes alignment already loads a data-phase word.
    assign align_done = (state == ST_ALIGN) && (align_cnt == ALIGN_LIMIT);
    assign data_phase = (state == ST_DATA) || align_done;
    assign link_up    = (state == ST_DATA);
    assign in_ready   = !rst && boundary && data_phase && !train_now && !skip_due;

`ifdef TX_SKIP_EN
    localparam int                SCNT_W     = $clog2(SKIP_INTERVAL + 1);
    localparam logic [SCNT_W-1:0] SKIP_LIMIT = SCNT_W'(SKIP_INTERVAL);

    logic [SCNT_W-1:0] skip_cnt;

    assign skip_due = (skip_cnt == SKIP_LIMIT);

    // Data-phase words since the last skip; held at zero outside the data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (boundary) begin
            if (train_now || !data_phase || skip_due) begin
                skip_cnt <= '0;
            end else begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end
`else
    assign skip_due = 1'b0;
`endif

    // Word chosen for the coming frame, in priority order.
    always_comb begin
        next_word = COMMA_A;
        next_idle = 1'b0;
        if (train_now) begin
            next_word = COMMA_A;
        end else if (!data_phase) begin
            next_word = align_cnt[0] ? COMMA_B : COMMA_A;
        end else if (skip_due) begin
            next_word = SKIP_WORD;
        end else if (in_valid) begin
            next_word = in_data;
        end else begin
            next_word = IDLE_WORD;
            next_idle = 1'b1;
        end
    end

    // Scheduler state, alignment progress, sticky train request and word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ALIGN;
            align_cnt  <= '0;
            train_pend <= 1'b0;
            ser_word   <= '0;
            ser_load   <= 1'b0;
            idle_sent  <= 1'b0;
        end else begin
            ser_load  <= boundary;
            idle_sent <= boundary && next_idle;
            if (boundary) begin
                ser_word   <= next_word;
                train_pend <= 1'b0;
                if (train_now) begin
                    // The COMMA_A loaded here is the first word of the new run.
                    state     <= ST_ALIGN;
                    align_cnt <= ACNT_W'(1);
                end else if (data_phase) begin
                    state <= ST_DATA;
                end else begin
                    align_cnt <= align_cnt + 1'b1;
                end
            end else if (train_req) begin
                train_pend <= 1'b1;
            end
        end
    end

endmodule
